led_ring_driver: RTL

//  Serialises a frame of 24-bit GRB pixels onto the display-board LED pixel ring (WS2812-class, one-wire).

---
 rtl/led_ring_pkg.sv | 10 +
 rtl/led_ring_driver.sv | 88 ++++++++
 2 files changed

// File: rtl/led_ring_pkg.sv
// led_ring_pkg: pixel colour type, driver state encoding and 50 MHz WS2812 timing defaults.
package led_ring_pkg;
  typedef struct packed {logic [7:0] g, r, b;} grbT;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_BIT, S_LATCH} ringStateT;
  localparam int NUM_LEDS_DEF = 60;
  localparam int T0H_CYC_DEF = 20;
  localparam int T1H_CYC_DEF = 40;
  localparam int BIT_CYC_DEF = 63;
  localparam int LATCH_CYC_DEF = 2600;
endpackage

// File: rtl/led_ring_driver.sv
// led_ring_driver: fetches GRB pixels by index and serialises them MSB-first onto a WS2812-class one-wire ring.
module led_ring_driver
  import led_ring_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int T0H_CYC = T0H_CYC_DEF,
  parameter int T1H_CYC = T1H_CYC_DEF,
  parameter int BIT_CYC = BIT_CYC_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF,
  localparam int IDX_W = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] pix_idx,
  input  grbT              pix_grb,
  output logic             ring_dout,
  output logic             busy,
  output logic             frame_done
);
  localparam int CNT_MAX = (BIT_CYC - 1) > LATCH_CYC ? (BIT_CYC - 1) : LATCH_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC);
  localparam logic [CNT_W-1:0] T0H = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H = CNT_W'(T1H_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  ringStateT        state_q;
  logic [23:0]      sh_q;
  logic [4:0]       bit_q;
  logic [CNT_W-1:0] cyc_q;
  logic [IDX_W-1:0] idx_q;
  logic             dout_q, busy_q, done_q;
  // The latch counter runs 0..LATCH_CYC so the line sits low for LATCH_CYC full cycles after the last bit's registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      bit_q <= '0;
      cyc_q <= '0;
      idx_q <= '0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dout_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_FETCH;
          busy_q <= 1'b1;
          idx_q <= '0;
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          sh_q <= pix_grb;
          bit_q <= 5'd23;
          cyc_q <= '0;
          state_q <= S_BIT;
        end
        S_BIT: begin
          dout_q <= cyc_q < (sh_q[23] ? T1H : T0H);
          if (cyc_q == BIT_LAST) begin
            cyc_q <= '0;
            sh_q <= {sh_q[22:0], 1'b0};
            if (bit_q != 5'd0) bit_q <= bit_q - 5'd1;
            else if (idx_q != IDX_LAST) begin
              idx_q <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end else state_q <= S_LATCH;
          end else cyc_q <= cyc_q + 1'b1;
        end
        S_LATCH: if (cyc_q == LATCH_LAST) begin
          cyc_q <= '0;
          idx_q <= '0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end else cyc_q <= cyc_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign pix_idx = idx_q;
  assign ring_dout = dout_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule
